// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: operand forwarding selects, load-use interlock and
// multi-cycle divide stall FSM. Optional stall-cycle counter behind HAZARD_PERF_EN.
module hazard_ctrl #(
    parameter int unsigned DIV_LAT = 32
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic [4:0] ex_rs,
    input  logic [4:0] ex_rt,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       id_use_rs,
    input  logic       id_use_rt,
    input  logic [4:0] ex_rd,
    input  logic [4:0] mem_rd,
    input  logic [4:0] wb_rd,
    input  logic       ex_wen,
    input  logic       mem_wen,
    input  logic       wb_wen,
    input  logic       ex_is_load,
    input  logic       ex_div_req,
    input  logic       pipe_flush,
    output logic [1:0] fwd_a_sel,
    output logic [1:0] fwd_b_sel,
    output logic       stall_if,
    output logic       stall_id,
    output logic       stall_ex,
    output logic       flush_ex,
    output logic       flush_mem,
    output logic       div_ready
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0] perf_stall_cnt
`endif
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // The IDLE start cycle is already a stall cycle, so BUSY covers DIV_LAT-1.
    localparam logic [5:0] CNT_LOAD = 6'(DIV_LAT - 2);

    state_t     state_q;
    logic [5:0] cnt_q;
    logic       div_ready_q;
    logic       div_stall;
    logic       load_use;

    function automatic logic [1:0] fwd_sel(input logic [4:0] src);
        if (mem_wen && (mem_rd != 5'd0) && (mem_rd == src)) begin
            return 2'd1;
        end else if (wb_wen && (wb_rd != 5'd0) && (wb_rd == src)) begin
            return 2'd2;
        end
        return 2'd0;
    endfunction

    assign fwd_a_sel = fwd_sel(ex_rs);
    assign fwd_b_sel = fwd_sel(ex_rt);

    always_comb begin
        load_use = 1'b0;
        if (resetn && !pipe_flush && ex_is_load && ex_wen && (ex_rd != 5'd0)) begin
            load_use = (id_use_rs && (ex_rd == id_rs)) || (id_use_rt && (ex_rd == id_rt));
        end
    end

    always_comb begin
        div_stall = 1'b0;
        if (resetn && !pipe_flush) begin
            div_stall = (state_q == S_BUSY) || ((state_q == S_IDLE) && ex_div_req);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= S_IDLE;
            cnt_q       <= 6'd0;
            div_ready_q <= 1'b0;
        end else if (pipe_flush) begin
            state_q     <= S_IDLE;
            cnt_q       <= 6'd0;
            div_ready_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (ex_div_req) begin
                        state_q <= S_BUSY;
                        cnt_q   <= CNT_LOAD;
                    end
                end
                S_BUSY: begin
                    if (cnt_q == 6'd0) begin
                        state_q     <= S_DONE;
                        div_ready_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 6'd1;
                    end
                end
                S_DONE: begin
                    // A request still held here belongs to the finished divide.
                    state_q     <= S_IDLE;
                    div_ready_q <= 1'b0;
                end
                default: begin
                    state_q     <= S_IDLE;
                    cnt_q       <= 6'd0;
                    div_ready_q <= 1'b0;
                end
            endcase
        end
    end

    assign stall_if  = load_use | div_stall;
    assign stall_id  = load_use | div_stall;
    assign stall_ex  = div_stall;
    assign flush_mem = div_stall;
    assign flush_ex  = load_use & ~div_stall;
    assign div_ready = div_ready_q;

`ifdef HAZARD_PERF_EN
    logic [31:0] perf_q;
    logic [31:0] perf_d;

    assign perf_d = stall_if ? perf_q + 32'd1 : perf_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            perf_q <= 32'd0;
        end else begin
            perf_q <= perf_d;
        end
    end

    assign perf_stall_cnt = perf_q;
`endif

endmodule
